stdp_weight_update: RTL and testbench
=====================================

// Module: stdp_weight_update
// PURPOSE
//  Consumer end of the STDP incr/decr interface: takes the level-held incr/decr/sim
//  outputs of the spike-timing direction selector and turns each new direction
//  event into one saturating step of a synaptic weight register.
//  Sits between the direction selector and the neuron's synaptic input scaling.
//  A hold (refractory) window after each update rate-limits plasticity.
// PARAMETERS
//  W_WIDTH   8    weight width in bits
//  W_INIT    128  weight value after reset
//  W_MAX     255  upper clamp (<= 2**W_WIDTH-1)
//  W_MIN     0    lower clamp (< W_MAX)
//  STEP_UP   4    potentiation step per incr event
//  STEP_DN   4    depression step per decr event
//  HOLD_CYC  3    cycles in HOLD after an update (>=1)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  en         in   1        plasticity enable; 0 = events ignored, weight frozen
//  incr       in   1        level from direction selector (potentiate)
//  decr       in   1        level from direction selector (depress)
//  sim        in   1        simultaneous pre/post spike flag (combinational upstream)
//  weight     out  W_WIDTH  current synaptic weight (registered)
//  upd_pulse  out  1        1-cycle pulse the cycle weight takes a new value
//  sat_hi     out  1        weight == W_MAX (registered)
//  sat_lo     out  1        weight == W_MIN (registered)
//  busy       out  1        1 while in HOLD
//  drop_cnt   out  8        events dropped during HOLD, saturates at 255
// BEHAVIOUR
//  Reset: weight=W_INIT, upd_pulse=0, busy=0, drop_cnt=0, sat_hi/sat_lo per W_INIT,
//   incr_q=decr_q=0, state=IDLE. Reset mid-HOLD aborts HOLD immediately.
//  Event detect: ev_up = incr & ~incr_q; ev_dn = decr & ~decr_q; incr_q/decr_q
//   register incr/decr every cycle regardless of state or en.
//   Upstream holds levels, so repeated same-direction spikes produce no new event.
//  Qualify: ev = en & ~sim & (ev_up ^ ev_dn). ev_up&ev_dn same cycle -> no event,
//   no drop count. sim=1 suppresses the event (not counted as drop).
//  FSM IDLE: on ev -> weight updates at that clock edge (latency 1 from event
//   cycle), upd_pulse=1 next cycle, hold counter loads HOLD_CYC, go HOLD.
//  FSM HOLD: busy=1; counter decrements each cycle; at 1 -> IDLE next edge
//   (busy high exactly HOLD_CYC cycles). ev in HOLD -> dropped, drop_cnt+1 (sat).
//  Arithmetic: sum computed in W_WIDTH+1 bits unsigned;
//   up: min(weight+STEP_UP, W_MAX); dn: weight<W_MIN+STEP_DN ? W_MIN : weight-STEP_DN.
//  Update at clamp (weight already W_MAX on up / W_MIN on dn): weight unchanged,
//   upd_pulse still 1, FSM still enters HOLD.
//  sat_hi/sat_lo reflect the registered weight (same cycle weight changes).
//  en=0: FSM finishes any HOLD; no new updates; drop_cnt unaffected.
// STRUCTURE
//  Shared package stdp_pkg: FSM state encodings (ST_IDLE, ST_HOLD), default
//   weight width/clamp constants shared with the neuron scaling block.
//  Sub-module stdp_edge_det (1-bit rising-edge detector, async reset) x2 for incr/decr.
//  Top holds FSM, hold counter, clamped adder, drop counter.
// TESTING (defaults)
//  Reset release, incr rises -> 1 cycle later weight=132, upd_pulse 1 cycle, busy 3 cycles.
//  incr held high 10 cycles -> single update only (weight 132), drop_cnt=0.
//  incr->decr toggle during HOLD -> weight stays 132, drop_cnt=1; after HOLD, next decr rise -> 128.
//  Weight 253, incr rise -> 255, sat_hi=1; second incr event -> 255, upd_pulse=1.
//  Weight 2, decr rise -> 0, sat_lo=1; sim=1 with incr rise -> no change, no drop.
//  rst asserted mid-HOLD -> weight=128, busy=0, drop_cnt=0 asynchronously.

Source files
------------

// File: rtl/stdp_pkg.sv
// stdp_pkg: FSM state encodings and default weight constants shared across the STDP path
package stdp_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
   localparam int DEF_W_WIDTH = 8;
   localparam int DEF_W_INIT  = 128;
   localparam int DEF_W_MAX   = 255;
   localparam int DEF_W_MIN   = 0;
endpackage

// File: rtl/stdp_edge_det.sv
// stdp_edge_det: 1-bit rising-edge detector for the level-held direction signals
module stdp_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);
   logic r_q;
   // delayed copy of the level, sampled every cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) r_q <= 1'b0;
      else     r_q <= i_d;
   assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/stdp_weight_update.sv
// stdp_weight_update: turns incr/decr direction events into rate-limited saturating weight steps
module stdp_weight_update
   import stdp_pkg::*;
#(
   parameter int W_WIDTH  = DEF_W_WIDTH,
   parameter int W_INIT   = DEF_W_INIT,
   parameter int W_MAX    = DEF_W_MAX,
   parameter int W_MIN    = DEF_W_MIN,
   parameter int STEP_UP  = 4,
   parameter int STEP_DN  = 4,
   parameter int HOLD_CYC = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               incr,
   input  logic               decr,
   input  logic               sim,
   output logic [W_WIDTH-1:0] weight,
   output logic               upd_pulse,
   output logic               sat_hi,
   output logic               sat_lo,
   output logic               busy,
   output logic [7:0]         drop_cnt
);
   localparam int CW = $clog2(HOLD_CYC + 1);
   localparam logic [CW-1:0]    L_HOLD = CW'(HOLD_CYC);
   localparam logic [CW-1:0]    L_ONE  = CW'(1);
   localparam logic [W_WIDTH:0] L_MAX  = (W_WIDTH + 1)'(W_MAX);
   localparam logic [W_WIDTH:0] L_MIN  = (W_WIDTH + 1)'(W_MIN);
   localparam logic [W_WIDTH:0] L_UP   = (W_WIDTH + 1)'(STEP_UP);
   localparam logic [W_WIDTH:0] L_DN   = (W_WIDTH + 1)'(STEP_DN);
   localparam logic [W_WIDTH-1:0] L_INIT = W_WIDTH'(W_INIT);

   logic w_up, w_dn, w_ev, w_take, w_drop;
   state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [W_WIDTH-1:0] r_weight, w_weight_nxt, w_up_val, w_dn_val;
   logic [W_WIDTH:0] w_sum_up, w_ext;
   logic r_upd, r_sat_hi, r_sat_lo;
   logic [7:0] r_drop;

   stdp_edge_det u_ed_incr (.clk(clk), .rst(rst), .i_d(incr), .o_rise(w_up));
   stdp_edge_det u_ed_decr (.clk(clk), .rst(rst), .i_d(decr), .o_rise(w_dn));

   assign w_ev     = en & ~sim & (w_up ^ w_dn);
   assign w_ext    = {1'b0, r_weight};
   assign w_sum_up = w_ext + L_UP;
   assign w_up_val = (w_sum_up > L_MAX) ? L_MAX[W_WIDTH-1:0] : w_sum_up[W_WIDTH-1:0];
   assign w_dn_val = (w_ext < L_MIN + L_DN) ? L_MIN[W_WIDTH-1:0] : r_weight - L_DN[W_WIDTH-1:0];
   assign w_weight_nxt = w_take ? (w_up ? w_up_val : w_dn_val) : r_weight;

   // next-state: accept an event in IDLE, count down the hold window, drop events while holding
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      w_drop      = 1'b0;
      if (r_state == ST_IDLE) begin
         w_take = w_ev;
         if (w_ev) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = L_HOLD;
         end
      end else begin
         w_drop    = w_ev;
         w_cnt_nxt = r_cnt - L_ONE;
         if (r_cnt == L_ONE) w_state_nxt = ST_IDLE;
      end
   end

   // FSM state and hold counter registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end

   // weight, update pulse and saturation flags all follow the same next-weight value
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_weight <= L_INIT;
         r_upd    <= 1'b0;
         r_sat_hi <= (W_INIT == W_MAX);
         r_sat_lo <= (W_INIT == W_MIN);
      end else begin
         r_weight <= w_weight_nxt;
         r_upd    <= w_take;
         r_sat_hi <= ({1'b0, w_weight_nxt} == L_MAX);
         r_sat_lo <= ({1'b0, w_weight_nxt} == L_MIN);
      end

   // saturating count of events lost to the hold window
   always_ff @(posedge clk or posedge rst)
      if (rst)                          r_drop <= '0;
      else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;

   assign weight    = r_weight;
   assign upd_pulse = r_upd;
   assign sat_hi    = r_sat_hi;
   assign sat_lo    = r_sat_lo;
   assign busy      = (r_state == ST_HOLD);
   assign drop_cnt  = r_drop;
endmodule

// File: tb/tb_stdp_weight_update.sv
// tb_stdp_weight_update: scoreboard bench with a cycle-level behavioural model of the weight updater
module tb_stdp_weight_update;
   typedef struct {
      int w;
      int upd;
      int busy;
      int drop;
      int hi;
      int lo;
   } exp_t;

   logic clk = 1'b0;
   logic rst, en, incr, decr, sim;
   logic [7:0] weight, drop_cnt;
   logic upd_pulse, sat_hi, sat_lo, busy;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int m_w, m_hold, m_drop, m_pi, m_pd;

   stdp_weight_update dut (
      .clk(clk), .rst(rst), .en(en), .incr(incr), .decr(decr), .sim(sim),
      .weight(weight), .upd_pulse(upd_pulse), .sat_hi(sat_hi), .sat_lo(sat_lo),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_w = 128; m_hold = 0; m_drop = 0; m_pi = 0; m_pd = 0;
   endtask

   // one clock: apply inputs, advance the model on the edge, queue what the DUT should show
   task automatic cyc(input bit i, input bit d, input bit e, input bit s);
      bit up, dn, ev, upd;
      int nh;
      exp_t x;
      incr = i; decr = d; en = e; sim = s;
      @(posedge clk);
      up  = i && !m_pi;
      dn  = d && !m_pd;
      ev  = e && !s && (up != dn);
      upd = 0;
      nh  = (m_hold > 0) ? m_hold - 1 : 0;
      if (ev && m_hold == 0) begin
         m_w = up ? ((m_w + 4 > 255) ? 255 : m_w + 4) : ((m_w - 4 < 0) ? 0 : m_w - 4);
         upd = 1;
         nh  = 3;
      end else if (ev) begin
         m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
      m_hold = nh;
      m_pi = i; m_pd = d;
      x.w = m_w; x.upd = upd; x.busy = (m_hold > 0); x.drop = m_drop;
      x.hi = (m_w == 255); x.lo = (m_w == 0);
      q.push_back(x);
      #2;
   endtask

   // monitor: every cycle the DUT presents registered outputs; compare with the oldest expectation
   always @(negedge clk) begin
      exp_t x;
      if (!rst && q.size() > 0) begin
         x = q.pop_front();
         chk("weight", int'(weight), x.w);
         chk("upd_pulse", int'(upd_pulse), x.upd);
         chk("busy", int'(busy), x.busy);
         chk("drop_cnt", int'(drop_cnt), x.drop);
         chk("sat_hi", int'(sat_hi), x.hi);
         chk("sat_lo", int'(sat_lo), x.lo);
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; incr = 1'b0; decr = 1'b0; sim = 1'b0;
      model_reset();
      #1;
      chk("rst_weight", int'(weight), 128);
      chk("rst_busy", int'(busy), 0);
      chk("rst_upd", int'(upd_pulse), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      chk("rst_sat_hi", int'(sat_hi), 0);
      chk("rst_sat_lo", int'(sat_lo), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      // first incr rise, then held high: one update only
      for (int k = 0; k < 10; k++) cyc(1, 0, 1, 0);
      cyc(0, 0, 1, 0);
      // incr then decr rise while holding: one drop, weight unchanged
      cyc(1, 0, 1, 0);
      cyc(0, 1, 1, 0);
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0);
      cyc(0, 1, 1, 0);
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0);
      // simultaneous rises, sim-suppressed and disabled events: no update, no drop
      cyc(1, 1, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 1, 1);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      // drive to the upper clamp and keep pushing
      for (int k = 0; k < 40; k++) begin
         cyc(1, 0, 1, 0);
         for (int j = 0; j < 4; j++) cyc(0, 0, 1, 0);
      end
      // drive to the lower clamp and keep pushing
      for (int k = 0; k < 70; k++) begin
         cyc(0, 1, 1, 0);
         for (int j = 0; j < 4; j++) cyc(0, 0, 1, 0);
      end
      // random traffic
      for (int k = 0; k < 800; k++)
         cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
      // build a drop count, then reset asynchronously in the middle of a hold window
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
      cyc(1, 0, 1, 0);
      cyc(0, 1, 1, 0);
      #4;
      incr = 1'b0; decr = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_hold_rst_weight", int'(weight), 128);
      chk("mid_hold_rst_busy", int'(busy), 0);
      chk("mid_hold_rst_drop", int'(drop_cnt), 0);
      chk("mid_hold_rst_upd", int'(upd_pulse), 0);
      chk("queue_drained_at_rst", q.size(), 0);
      q.delete();
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0);
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0);
      @(negedge clk);
      #1;
      chk("queue_empty_at_end", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
